// File: rtl/pu_msp430_wakeup_ctrl.sv
// Mclk-domain wakeup controller: synchronizes the capture-cell flag, runs the req/ack
// handshake, pulses wkup_clear back to the cell and counts serviced wakeups.
// Optional ack timeout is enabled by defining WKUP_ACK_TIMEOUT_EN.
module pu_msp430_wakeup_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       wkup_in,
  input  logic       wkup_en,
  input  logic       wkup_ack,
  input  logic       wkup_to_clr,
  output logic       wkup_req,
  output logic       wkup_clear,
  output logic       wkup_busy,
  output logic       wkup_timeout,
  output logic [7:0] wkup_cnt
);

  localparam int CYC_MAX = (CLR_CYCLES > SYNC_STAGES) ? CLR_CYCLES : SYNC_STAGES;
  localparam int CW      = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, CLEAR, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   wkup_s;
  logic                   ack_q;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic                   cnt_inc;
  logic                   timeout_set;
  logic                   timer_hit;

  assign wkup_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wkup_in};
    end
  end

  // Ack is registered so it only ever acts in REQ, one edge after it is sampled.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wkup_ack & (state_q == REQ);
    end
  end

`ifdef WKUP_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] timer_q;
  logic          timeout_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (state_q != REQ) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timer_hit = (timer_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end else if (wkup_to_clr) begin
      timeout_q <= 1'b0;
    end
  end

  assign wkup_timeout = timeout_q;
`else
  localparam int unused_ack_timeout = ACK_TIMEOUT;

  logic unused_cfg;

  assign timer_hit    = 1'b0;
  assign wkup_timeout = 1'b0;
  assign unused_cfg   = wkup_to_clr | timeout_set;
`endif

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // In REQ an ack beats a dropped enable, which beats the timeout.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (wkup_s) begin
          state_d = wkup_en ? REQ : CLEAR;
        end
      end
      REQ: begin
        cyc_d = '0;
        if (ack_q) begin
          state_d = CLEAR;
          cnt_inc = 1'b1;
        end else if (!wkup_en) begin
          state_d = CLEAR;
        end else if (timer_hit) begin
          state_d     = CLEAR;
          timeout_set = 1'b1;
        end
      end
      CLEAR: begin
        if (cyc_q == CW'(CLR_CYCLES - 1)) begin
          state_d = WAIT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      WAIT: begin
        if (cyc_q == CW'(SYNC_STAGES - 1)) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state into flops so they are glitch-free.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wkup_req   <= 1'b0;
      wkup_clear <= 1'b0;
      wkup_busy  <= 1'b0;
      wkup_cnt   <= 8'd0;
    end else begin
      wkup_req   <= (state_d == REQ);
      wkup_clear <= (state_d == CLEAR);
      wkup_busy  <= (state_d != IDLE);
      if (cnt_inc) begin
        wkup_cnt <= wkup_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pu_msp430_wakeup_ctrl.sv
// Self-checking bench for pu_msp430_wakeup_ctrl: a vector table for the basic handshake
// plus directed sequences for wrap, enable drop, timeout and mid-operation reset.
module tb_pu_msp430_wakeup_ctrl;

`ifdef WKUP_ACK_TIMEOUT_EN
  localparam int ACK_TO = 4;
`else
  localparam int ACK_TO = 255;
`endif

  logic       mclk = 1'b0;
  logic       reset_n;
  logic       wkup_in;
  logic       wkup_en;
  logic       wkup_ack;
  logic       wkup_to_clr;
  logic       wkup_req;
  logic       wkup_clear;
  logic       wkup_busy;
  logic       wkup_timeout;
  logic [7:0] wkup_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic       in;
    logic       en;
    logic       ack;
    logic       to_clr;
    logic       req;
    logic       clr;
    logic       busy;
    logic       tmo;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[20];

  pu_msp430_wakeup_ctrl #(
    .SYNC_STAGES(2),
    .CLR_CYCLES (2),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .wkup_in     (wkup_in),
    .wkup_en     (wkup_en),
    .wkup_ack    (wkup_ack),
    .wkup_to_clr (wkup_to_clr),
    .wkup_req    (wkup_req),
    .wkup_clear  (wkup_clear),
    .wkup_busy   (wkup_busy),
    .wkup_timeout(wkup_timeout),
    .wkup_cnt    (wkup_cnt)
  );

  always #5 mclk = ~mclk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got time-out, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic i, input logic e, input logic a, input logic t);
    wkup_in     = i;
    wkup_en     = e;
    wkup_ack    = a;
    wkup_to_clr = t;
  endtask

  task automatic check_all(input string tag, input logic r, input logic c, input logic b,
                           input logic t, input logic [7:0] n);
    check_output({tag, "_req"}, wkup_req, r);
    check_output({tag, "_clear"}, wkup_clear, c);
    check_output({tag, "_busy"}, wkup_busy, b);
    check_output({tag, "_timeout"}, wkup_timeout, t);
    check_output({tag, "_cnt"}, wkup_cnt, n);
  endtask

  // sel: 0 = wkup_req, 1 = wkup_clear, 2 = wkup_busy
  task automatic wait_until(input string name, input int sel, input logic val, input int max_cycles);
    logic hit;
    logic cur;
    hit = 1'b0;
    for (int k = 0; k < max_cycles && !hit; k++) begin
      step();
      cur = (sel == 0) ? wkup_req : (sel == 1) ? wkup_clear : wkup_busy;
      hit = (cur === val);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("[TB] FAIL %s: got no change in %0d cycles, expected %0b", name, max_cycles, val);
    end
  endtask

  task automatic service_one(input string tag);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_until({tag, "_req"}, 0, 1'b1, 10);
    wkup_ack = 1'b1;
    step();
    wkup_ack = 1'b0;
    step();
    exp_cnt = exp_cnt + 8'd1;
    check_output({tag, "_clear"}, wkup_clear, 1'b1);
    check_output({tag, "_cnt"}, wkup_cnt, exp_cnt);
    wkup_in = 1'b0;
    wait_until({tag, "_idle"}, 2, 1'b0, 20);
  endtask

  initial begin
    logic hold_bad;

    //               in    en    ack   toclr   req   clr   busy  tmo   cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    // Reset held with the flag already high: everything stays at zero.
    reset_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt = 8'd0;
    #3;
    check_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    step();
    check_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Edge k of the table is the k-th rising edge after release.
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].in, vecs[i].en, vecs[i].ack, vecs[i].to_clr);
      step();
      check_all($sformatf("vec%0d", i + 1), vecs[i].req, vecs[i].clr, vecs[i].busy,
                vecs[i].tmo, vecs[i].cnt);
    end
    exp_cnt = 8'd1;

    // Counter wrap 255 -> 0.
    for (int i = 0; i < 254; i++) begin
      service_one("fill");
    end
    check_output("cnt_255", wkup_cnt, 8'd255);
    service_one("wrap");
    check_output("cnt_wrap", wkup_cnt, 8'd0);

    // Enable dropped while requesting: abort without counting.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_until("endrop_req", 0, 1'b1, 10);
    wkup_en = 1'b0;
    step();
    check_all("endrop", 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    wait_until("endrop_idle", 2, 1'b0, 20);

`ifdef WKUP_ACK_TIMEOUT_EN
    // Timeout with wkup_to_clr held: the set must win at the expiry edge.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    wait_until("to_req", 0, 1'b1, 10);
    for (int k = 1; k < 4; k++) begin
      step();
      check_output($sformatf("to_hold%0d", k), wkup_req, 1'b1);
    end
    step();
    check_all("to_expire", 1'b0, 1'b1, 1'b1, 1'b1, exp_cnt);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_output("to_sticky", wkup_timeout, 1'b1);
    wkup_to_clr = 1'b1;
    step();
    check_output("to_cleared", wkup_timeout, 1'b0);
    wkup_to_clr = 1'b0;
    wait_until("to_idle", 2, 1'b0, 20);
`else
    // Without the timer the request is held indefinitely.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    wait_until("hold_req_rise", 0, 1'b1, 10);
    hold_bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (wkup_req !== 1'b1 || wkup_timeout !== 1'b0) hold_bad = 1'b1;
    end
    check_output("hold_1000", hold_bad, 1'b0);
    wkup_to_clr = 1'b0;
    wkup_ack    = 1'b1;
    step();
    wkup_ack = 1'b0;
    step();
    exp_cnt = exp_cnt + 8'd1;
    check_all("hold_done", 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);
    wkup_in = 1'b0;
    wait_until("hold_idle", 2, 1'b0, 20);
`endif

    // Asynchronous reset while CLEAR is active, then a fresh event after release.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_until("mid_req", 0, 1'b1, 10);
    wkup_ack = 1'b1;
    step();
    wkup_ack = 1'b0;
    step();
    check_output("mid_clear_on", wkup_clear, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    exp_cnt = 8'd0;
    wkup_in = 1'b0;
    step();
    reset_n = 1'b1;
    wkup_in = 1'b1;
    step();
    step();
    check_output("post_rst_e2", wkup_req, 1'b0);
    step();
    check_output("post_rst_e3", wkup_req, 1'b1);
    wkup_ack = 1'b1;
    step();
    wkup_ack = 1'b0;
    step();
    exp_cnt = exp_cnt + 8'd1;
    check_all("post_rst_done", 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);
    wkup_in = 1'b0;
    wait_until("post_rst_idle", 2, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
